// File: rtl/wb_arb_pkg.sv
// Shared constants for the Wishbone port arbiter: CTI codes, port FSM states, header layout.
package wb_arb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int HDR_CTI_LSB = 0;
    localparam int HDR_BTE_LSB = 3;
    localparam int HDR_WE_BIT  = 5;
    localparam int HDR_ADR_LSB = 6;

    typedef enum logic [1:0] {
        ST_HDR    = 2'd0,
        ST_WDATA  = 2'd1,
        ST_RDWAIT = 2'd2
    } port_st_e;

    function automatic logic cti_last(input logic [2:0] cti);
        return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
    endfunction

    function automatic int cmd_width(input int aw, input int dw);
        return ((dw + dw / 8) > (aw + 6)) ? (dw + dw / 8) : (aw + 6);
    endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// Rotating first-match picker: searches req starting at ptr, returns one-hot grant and index.
// Purely combinational; zero latency, no backpressure of its own.
module wb_arb_pick #(
    parameter int NPORTS = 4,
    parameter int IW     = 2
) (
    input  logic [NPORTS-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic [NPORTS-1:0] gnt,
    output logic [IW-1:0]     idx
);

    int            cand;
    logic [IW-1:0] c;

    // Walk the rotation backwards so the earliest requester after ptr is written last.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        cand = 0;
        c    = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            cand = int'(ptr) + i;
            if (cand >= NPORTS) cand = cand - NPORTS;
            c = IW'(cand);
            if (req[c]) begin
                gnt    = '0;
                gnt[c] = 1'b1;
                idx    = c;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// N-port Wishbone front end serialising headers/write data into one command stream; zero-latency
// combinational grant, cmd_ready_i low holds grant and acks. WB_ARB_RR_EN selects round-robin.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int          NPORTS       = 4,
    parameter int          AW           = 30,
    parameter int          DW           = 32,
    parameter logic [7:0]  HI_PRIO_MASK = 8'h00,
    localparam int         SW           = DW / 8,
    localparam int         CW           = cmd_width(AW, DW)
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
    input  logic [NPORTS*DW-1:0] wbs_dat_i,
    input  logic [NPORTS*AW-1:0] wbs_adr_i,
    input  logic [NPORTS*SW-1:0] wbs_sel_i,
    input  logic [NPORTS*3-1:0]  wbs_cti_i,
    input  logic [NPORTS*2-1:0]  wbs_bte_i,
    input  logic [NPORTS-1:0]    wbs_we_i,
    input  logic [NPORTS-1:0]    wbs_cyc_i,
    input  logic [NPORTS-1:0]    wbs_stb_i,
    output logic [NPORTS*DW-1:0] wbs_dat_o,
    output logic [NPORTS-1:0]    wbs_ack_o,
    output logic [CW-1:0]        cmd_dat_o,
    output logic                 cmd_hdr_o,
    output logic [2:0]           cmd_port_o,
    output logic                 cmd_valid_o,
    input  logic                 cmd_ready_i,
    output logic                 cmd_abort_o,
    input  logic [DW-1:0]        rd_dat_i,
    input  logic [2:0]           rd_port_i,
    input  logic                 rd_ack_i
);

    localparam int                IW      = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [NPORTS-1:0] HI_MASK = HI_PRIO_MASK[NPORTS-1:0];

    logic [DW-1:0] dat [NPORTS];
    logic [AW-1:0] adr [NPORTS];
    logic [SW-1:0] sel [NPORTS];
    logic [2:0]    cti [NPORTS];
    logic [1:0]    bte [NPORTS];

    port_st_e          st_q [NPORTS];
    port_st_e          st_d [NPORTS];
    logic              lock_vld_q, lock_vld_d;
    logic [IW-1:0]     lock_port_q, lock_port_d;
    logic              hold_vld_q, hold_vld_d;
    logic [IW-1:0]     hold_port_q, hold_port_d;
    logic [NPORTS-1:0] req, gnt_hi, gnt_lo;
    logic [IW-1:0]     idx_hi, idx_lo, ptr, gp, sp;
    logic              use_hold, any_req;
    logic [CW-1:0]     hdr_word, data_word;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        assign dat[p] = wbs_dat_i[p*DW +: DW];
        assign adr[p] = wbs_adr_i[p*AW +: AW];
        assign sel[p] = wbs_sel_i[p*SW +: SW];
        assign cti[p] = wbs_cti_i[p*3 +: 3];
        assign bte[p] = wbs_bte_i[p*2 +: 2];
        assign req[p] = (st_q[p] == ST_HDR) && wbs_cyc_i[p] && wbs_stb_i[p];
        assign wbs_dat_o[p*DW +: DW] = rd_dat_i;
    end

`ifdef WB_ARB_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;
    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    wb_arb_pick #(.NPORTS(NPORTS), .IW(IW)) u_pick_hi (
        .req (req & HI_MASK),
        .ptr (ptr),
        .gnt (gnt_hi),
        .idx (idx_hi)
    );

    wb_arb_pick #(.NPORTS(NPORTS), .IW(IW)) u_pick_lo (
        .req (req & ~HI_MASK),
        .ptr (ptr),
        .gnt (gnt_lo),
        .idx (idx_lo)
    );

    // A header stalled by cmd_ready_i keeps its grant even if a better request shows up.
    assign use_hold = hold_vld_q && req[hold_port_q];
    assign any_req  = use_hold || (|gnt_hi) || (|gnt_lo);
    assign gp       = use_hold ? hold_port_q : ((|gnt_hi) ? idx_hi : idx_lo);
    assign sp       = lock_vld_q ? lock_port_q : gp;

    always_comb begin
        hdr_word = '0;
        hdr_word[HDR_CTI_LSB +: 3]  = cti[sp];
        hdr_word[HDR_BTE_LSB +: 2]  = bte[sp];
        hdr_word[HDR_WE_BIT]        = wbs_we_i[sp];
        hdr_word[HDR_ADR_LSB +: AW] = adr[sp];
    end

    assign data_word = CW'({dat[sp], sel[sp]});

    always_comb begin
        st_d        = st_q;
        lock_vld_d  = lock_vld_q;
        lock_port_d = lock_port_q;
        hold_vld_d  = 1'b0;
        hold_port_d = hold_port_q;
`ifdef WB_ARB_RR_EN
        ptr_d       = ptr_q;
`endif
        cmd_valid_o = 1'b0;
        cmd_abort_o = 1'b0;
        cmd_hdr_o   = !lock_vld_q;
        cmd_port_o  = 3'(sp);
        cmd_dat_o   = lock_vld_q ? data_word : hdr_word;
        wbs_ack_o   = '0;

        if (lock_vld_q) begin
            if (!wbs_cyc_i[lock_port_q]) begin
                cmd_abort_o             = 1'b1;
                st_d[lock_port_q]       = ST_HDR;
                lock_vld_d              = 1'b0;
            end else begin
                cmd_valid_o = wbs_stb_i[lock_port_q];
                if (cmd_valid_o && cmd_ready_i) begin
                    wbs_ack_o[lock_port_q] = 1'b1;
                    if (cti_last(cti[lock_port_q])) begin
                        st_d[lock_port_q] = ST_HDR;
                        lock_vld_d        = 1'b0;
                    end
                end
            end
        end else if (any_req) begin
            cmd_valid_o = 1'b1;
            if (cmd_ready_i) begin
                if (wbs_we_i[gp]) begin
                    st_d[gp]    = ST_WDATA;
                    lock_vld_d  = 1'b1;
                    lock_port_d = gp;
                end else begin
                    st_d[gp] = ST_RDWAIT;
                end
`ifdef WB_ARB_RR_EN
                ptr_d = (gp == IW'(NPORTS - 1)) ? '0 : gp + 1'b1;
`endif
            end else begin
                hold_vld_d  = 1'b1;
                hold_port_d = gp;
            end
        end

        // Read return never touches the command stream, so it can ack alongside a write beat.
        for (int p = 0; p < NPORTS; p++) begin
            if (st_q[p] == ST_RDWAIT) begin
                if (!wbs_cyc_i[p]) begin
                    st_d[p] = ST_HDR;
                end else if (rd_ack_i && (rd_port_i == 3'(p))) begin
                    wbs_ack_o[p] = 1'b1;
                    if (cti_last(cti[p])) st_d[p] = ST_HDR;
                end
            end
        end

        if (wb_rst) begin
            cmd_valid_o = 1'b0;
            cmd_abort_o = 1'b0;
            wbs_ack_o   = '0;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            for (int p = 0; p < NPORTS; p++) st_q[p] <= ST_HDR;
            lock_vld_q  <= 1'b0;
            lock_port_q <= '0;
            hold_vld_q  <= 1'b0;
            hold_port_q <= '0;
`ifdef WB_ARB_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            st_q        <= st_d;
            lock_vld_q  <= lock_vld_d;
            lock_port_q <= lock_port_d;
            hold_vld_q  <= hold_vld_d;
            hold_port_q <= hold_port_d;
`ifdef WB_ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

endmodule
